// File: rtl/xcalc_pkg.sv
// Shared calculator constants: key codes, result width, blank digit code,
// formatter FSM states and an elaboration-time power-of-ten helper.
package xcalc_pkg;

  localparam logic [3:0] KEY_PLUS    = 4'd10;
  localparam logic [3:0] KEY_MINUS   = 4'd11;
  localparam logic [3:0] KEY_MULT    = 4'd12;
  localparam logic [3:0] KEY_DIV     = 4'd13;
  localparam logic [3:0] KEY_ENTER   = 4'd14;

  localparam int         RES_W_DEF   = 11;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } fmt_state_t;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/xres_fmt_if.sv
// Start/busy/done handshake and result bus between the operator block and
// the formatter; master drives the request, slave is the formatter.
interface xres_fmt_if
  import xcalc_pkg::*;
#(
  parameter int RES_W = RES_W_DEF,
  parameter int NDIG  = 4
);
  logic               start;
  logic [RES_W-1:0]   value;
  logic               busy;
  logic               done;
  logic               negative;
  logic [4*NDIG-1:0]  bcd;

  modport master (output start, output value,
                  input busy, input done, input negative, input bcd);
  modport slave  (input start, input value,
                  output busy, output done, output negative, output bcd);
endinterface

// File: rtl/xres_fmt_bcd_add3.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? (d + 4'd3) : d;
endmodule

// File: rtl/xres_fmt.sv
// Iterative double-dabble formatter: signed result -> sign + NDIG BCD digits.
// Define XRES_FMT_BLANK_EN to output leading zero digits as DIGIT_BLANK.
module xres_fmt
  import xcalc_pkg::*;
#(
  parameter int RES_W = RES_W_DEF,
  parameter int NDIG  = 4
) (
  input  logic        clk,
  input  logic        rst,
  xres_fmt_if.slave   bus
);
  localparam int SCR_W = 4*NDIG + RES_W;
  localparam int CNT_W = $clog2(RES_W + 1);

  if (pow10(NDIG) <= (64'd1 << (RES_W - 1))) begin : g_ndig_check
    $error("xres_fmt: NDIG too small for RES_W");
  end

  fmt_state_t        state_r, state_nx;
  logic [CNT_W-1:0]  cnt_r, cnt_nx;
  logic [SCR_W-1:0]  scratch_r, scratch_nx;
  logic              sgn_r, sgn_nx;
  logic              busy_r, busy_nx;
  logic              done_r, done_nx;
  logic              neg_r, neg_nx;
  logic [4*NDIG-1:0] bcd_r, bcd_nx;
  logic [4*NDIG-1:0] corr_s;
  logic [SCR_W-1:0]  pre_shift_s;

  for (genvar i = 0; i < NDIG; i++) begin : g_add3
    bcd_add3 u_add3 (.d(scratch_r[RES_W + 4*i +: 4]), .q(corr_s[4*i +: 4]));
  end

  assign pre_shift_s = {corr_s, scratch_r[RES_W-1:0]};

  // Leading zeros become blanks; the ones digit always stays visible.
  function automatic logic [4*NDIG-1:0] blank_lz(input logic [4*NDIG-1:0] d);
    logic [4*NDIG-1:0] r;
    logic              lead;
    r    = d;
    lead = 1'b1;
    for (int i = NDIG - 1; i > 0; i--) begin
      if (lead && (d[4*i +: 4] == 4'h0)) r[4*i +: 4] = DIGIT_BLANK;
      else                               lead = 1'b0;
    end
    return r;
  endfunction

  always_comb begin
    state_nx   = state_r;
    cnt_nx     = cnt_r;
    scratch_nx = scratch_r;
    sgn_nx     = sgn_r;
    busy_nx    = busy_r;
    done_nx    = 1'b0;
    neg_nx     = neg_r;
    bcd_nx     = bcd_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          sgn_nx     = bus.value[RES_W-1];
          scratch_nx = {{(4*NDIG){1'b0}},
                        bus.value[RES_W-1] ? (~bus.value + RES_W'(1)) : bus.value};
          cnt_nx     = {CNT_W{1'b0}};
          busy_nx    = 1'b1;
          state_nx   = SHIFT;
        end else begin
          state_nx   = IDLE;
        end
      end
      SHIFT: begin
        scratch_nx = {pre_shift_s[SCR_W-2:0], 1'b0};
        cnt_nx     = cnt_r + CNT_W'(1);
        if (cnt_r == CNT_W'(RES_W - 1)) state_nx = FIN;
        else                            state_nx = SHIFT;
      end
      FIN: begin
`ifdef XRES_FMT_BLANK_EN
        bcd_nx   = blank_lz(scratch_r[SCR_W-1:RES_W]);
`else
        bcd_nx   = scratch_r[SCR_W-1:RES_W];
`endif
        neg_nx   = sgn_r;
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      scratch_r <= {SCR_W{1'b0}};
      sgn_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      neg_r     <= 1'b0;
      bcd_r     <= {(4*NDIG){1'b0}};
    end else begin
      state_r   <= state_nx;
      cnt_r     <= cnt_nx;
      scratch_r <= scratch_nx;
      sgn_r     <= sgn_nx;
      busy_r    <= busy_nx;
      done_r    <= done_nx;
      neg_r     <= neg_nx;
      bcd_r     <= bcd_nx;
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.negative = neg_r;
  assign bus.bcd      = bcd_r;

endmodule

// File: tb/tb_xres_fmt.sv
// Directed self-checking bench for xres_fmt (both blanking builds).
module tb_xres_fmt;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  xres_fmt_if #(.RES_W(11), .NDIG(4)) bus ();

  xres_fmt #(.RES_W(11), .NDIG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef XRES_FMT_BLANK_EN
  localparam logic [15:0] EXP_ZERO = 16'hFFF0;
  localparam logic [15:0] EXP_N7   = 16'hFFF7;
  localparam logic [15:0] EXP_5    = 16'hFFF5;
  localparam logic [15:0] EXP_N1   = 16'hFFF1;
  localparam logic [15:0] EXP_42   = 16'hFF42;
  localparam logic [15:0] EXP_43   = 16'hFF43;
`else
  localparam logic [15:0] EXP_ZERO = 16'h0000;
  localparam logic [15:0] EXP_N7   = 16'h0007;
  localparam logic [15:0] EXP_5    = 16'h0005;
  localparam logic [15:0] EXP_N1   = 16'h0001;
  localparam logic [15:0] EXP_42   = 16'h0042;
  localparam logic [15:0] EXP_43   = 16'h0043;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request one conversion and wait for done; lat = edges from accept to done or -1.
  task automatic convert(input logic [10:0] v, output int lat, output int busy_bad);
    logic got;
    busy_bad  = 0;
    lat       = 0;
    got       = 1'b0;
    bus.value = v;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    if (bus.busy !== 1'b1) busy_bad++;
    while (!got && lat < 40) begin
      tick();
      lat++;
      if (bus.done === 1'b1) got = 1'b1;
      else if (bus.busy !== 1'b1) busy_bad++;
    end
    if (!got) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.value = 11'd0;
    tick();
    tick();
    checks += 4;
    if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    if (bus.negative !== 1'b0)  begin errors++; $display("FAIL reset_neg: got %b expected 0", bus.negative); end
    if (bus.bcd !== 16'h0000)   begin errors++; $display("FAIL reset_bcd: got %h expected 0000", bus.bcd); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    int lat, bb;
    convert(11'd0, lat, bb);
    checks += 3;
    if (lat !== 12)             begin errors++; $display("FAIL zero_lat: got %0d expected 12", lat); end
    if (bus.bcd !== EXP_ZERO)   begin errors++; $display("FAIL zero_bcd: got %h expected %h", bus.bcd, EXP_ZERO); end
    if (bus.negative !== 1'b0)  begin errors++; $display("FAIL zero_neg: got %b expected 0", bus.negative); end
  endtask

  task automatic test_max();
    int lat, bb;
    convert(11'd1023, lat, bb);
    checks += 5;
    if (lat !== 12)             begin errors++; $display("FAIL max_lat: got %0d expected 12", lat); end
    if (bb !== 0)               begin errors++; $display("FAIL max_busy: %0d low samples expected 0", bb); end
    if (bus.busy !== 1'b0)      begin errors++; $display("FAIL max_busy_done: got %b expected 0", bus.busy); end
    if (bus.bcd !== 16'h1023)   begin errors++; $display("FAIL max_bcd: got %h expected 1023", bus.bcd); end
    if (bus.negative !== 1'b0)  begin errors++; $display("FAIL max_neg: got %b expected 0", bus.negative); end
    tick();
    checks += 2;
    if (bus.done !== 1'b0)      begin errors++; $display("FAIL max_pulse: got %b expected 0", bus.done); end
    if (bus.bcd !== 16'h1023)   begin errors++; $display("FAIL max_hold: got %h expected 1023", bus.bcd); end
  endtask

  task automatic test_negative();
    int lat, bb;
    convert(11'h400, lat, bb);
    checks += 3;
    if (lat !== 12)             begin errors++; $display("FAIL min_lat: got %0d expected 12", lat); end
    if (bus.bcd !== 16'h1024)   begin errors++; $display("FAIL min_bcd: got %h expected 1024", bus.bcd); end
    if (bus.negative !== 1'b1)  begin errors++; $display("FAIL min_neg: got %b expected 1", bus.negative); end
    convert(11'h7F9, lat, bb);
    checks += 3;
    if (lat !== 12)             begin errors++; $display("FAIL n7_lat: got %0d expected 12", lat); end
    if (bus.bcd !== EXP_N7)     begin errors++; $display("FAIL n7_bcd: got %h expected %h", bus.bcd, EXP_N7); end
    if (bus.negative !== 1'b1)  begin errors++; $display("FAIL n7_neg: got %b expected 1", bus.negative); end
  endtask

  task automatic test_ignore_and_reset();
    int lat, extra, bb;
    logic got;
    bus.value = 11'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.value = 11'd0;
    tick();
    tick();
    bus.value = 11'd999;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 3;
    got = 1'b0;
    while (!got && lat < 40) begin
      tick();
      lat++;
      if (bus.done === 1'b1) got = 1'b1;
    end
    checks += 3;
    if (!got || lat !== 12)     begin errors++; $display("FAIL ign_lat: got %0d expected 12", got ? lat : -1); end
    if (bus.bcd !== EXP_5)      begin errors++; $display("FAIL ign_bcd: got %h expected %h", bus.bcd, EXP_5); end
    if (bus.negative !== 1'b0)  begin errors++; $display("FAIL ign_neg: got %b expected 0", bus.negative); end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done === 1'b1) extra++;
    end
    checks += 1;
    if (extra !== 0)            begin errors++; $display("FAIL ign_single_done: got %0d extra expected 0", extra); end

    bus.value = 11'd300;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    checks += 4;
    if (bus.busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0)      begin errors++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
    if (bus.negative !== 1'b0)  begin errors++; $display("FAIL midrst_neg: got %b expected 0", bus.negative); end
    if (bus.bcd !== 16'h0000)   begin errors++; $display("FAIL midrst_bcd: got %h expected 0000", bus.bcd); end
    rst = 1'b0;
    tick();
    convert(11'h7FF, lat, bb);
    checks += 3;
    if (lat !== 12)             begin errors++; $display("FAIL post_lat: got %0d expected 12", lat); end
    if (bus.bcd !== EXP_N1)     begin errors++; $display("FAIL post_bcd: got %h expected %h", bus.bcd, EXP_N1); end
    if (bus.negative !== 1'b1)  begin errors++; $display("FAIL post_neg: got %b expected 1", bus.negative); end
  endtask

  task automatic test_back_to_back();
    int lat, gap, hold_bad;
    logic got;
    bus.value = 11'd42;
    bus.start = 1'b1;
    tick();
    bus.value = 11'd43;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      tick();
      lat++;
      if (bus.done === 1'b1) got = 1'b1;
    end
    checks += 2;
    if (!got || lat !== 12)     begin errors++; $display("FAIL b2b_lat: got %0d expected 12", got ? lat : -1); end
    if (bus.bcd !== EXP_42)     begin errors++; $display("FAIL b2b_bcd42: got %h expected %h", bus.bcd, EXP_42); end
    gap = 0;
    hold_bad = 0;
    got = 1'b0;
    while (!got && gap < 40) begin
      tick();
      gap++;
      if (bus.done === 1'b1) got = 1'b1;
      else if (bus.bcd !== EXP_42) hold_bad++;
    end
    bus.start = 1'b0;
    checks += 4;
    if (!got || gap !== 13)     begin errors++; $display("FAIL b2b_period: got %0d expected 13", got ? gap : -1); end
    if (hold_bad !== 0)         begin errors++; $display("FAIL b2b_hold: %0d changed samples expected 0", hold_bad); end
    if (bus.bcd !== EXP_43)     begin errors++; $display("FAIL b2b_bcd43: got %h expected %h", bus.bcd, EXP_43); end
    if (bus.negative !== 1'b0)  begin errors++; $display("FAIL b2b_neg: got %b expected 0", bus.negative); end
    repeat (15) tick();
    checks += 1;
    if (bus.busy !== 1'b0)      begin errors++; $display("FAIL b2b_idle: got %b expected 0", bus.busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.value = 11'd0;
    tick();
    test_reset();
    test_zero();
    test_max();
    test_negative();
    test_ignore_and_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
